apb_regfile_slave: RTL and testbench

Parametrised APB completer: an APB slave that decodes `paddr` into a bank of `NUM_REGS` word registers. It is the next generation of the APB interface used by the testbench driver and monitor, and adds four things:

- byte strobes (`pstrb`)
- programmable wait states
- per-register read-only masking
- `pslave_error` reporting

It sits on the DUT side of the APB interface and exposes register contents and write pulses to downstream hardware.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_reg_bank.sv | 44 ++++
 rtl/apb_regfile_slave.sv | 110 +++++++++++
 tb/tb_apb_regfile_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB completer types: FSM states, error flags and lane helper.
// Latency: n/a (definitions only); backpressure: n/a.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_MAX_WAIT = 15;

   typedef struct packed {
      logic unaligned;
      logic out_of_range;
      logic ro_write;
   } apb_err_t;

   function automatic int apb_byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Word register storage with byte-strobe writes and one-cycle write pulses.
// Latency: write visible on reg_out one cycle after wr_vld; backpressure: none, always accepts.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic                         pclk,
   input  logic                         presetn,
   input  logic                         wr_vld,
   input  logic [IDX_W-1:0]             wr_idx,
   input  logic [DATA_W-1:0]            wr_dat,
   input  logic [DATA_W/8-1:0]          wr_strb,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out,
   output logic [NUM_REGS-1:0]          wr_pulse
);

   localparam int LANES = apb_byte_lanes(DATA_W);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         if (wr_vld) begin
            // An all-zero strobe still counts as a committed write for the pulse.
            wr_pulse[wr_idx] <= 1'b1;
            for (int j = 0; j < LANES; j++) begin
               if (wr_strb[j]) regs[wr_idx][8*j +: 8] <= wr_dat[8*j +: 8];
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign reg_out[i*DATA_W +: DATA_W] = regs[i];
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer decoding paddr into NUM_REGS word registers with strobes, RO masking and errors.
// Latency: 2 + WAIT_CYCLES cycles per transfer; backpressure: pready held low for WAIT_CYCLES access cycles.
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int                  ADDR_W      = 32,
   parameter int                  DATA_W      = 32,
   parameter int                  NUM_REGS    = 16,
   parameter int                  WAIT_CYCLES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                         pclk,
   input  logic                         presetn,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   input  logic                         pwrite,
   input  logic                         pselx,
   input  logic                         penable,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslave_error,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out,
   input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
   output logic [NUM_REGS-1:0]          wr_pulse
);

   localparam int LANES = apb_byte_lanes(DATA_W);
   localparam int OFF_W = $clog2(LANES);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CNT_W = $clog2(APB_MAX_WAIT + 1);

   apb_state_e state, state_nxt, phase;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [ADDR_W-1:0] word_idx;
   logic [IDX_W-1:0]  reg_idx;
   apb_err_t          err;
   logic              error;
   logic              complete;
   logic              commit;
   logic [DATA_W-1:0] rd_word;

   assign word_idx = paddr >> OFF_W;
   assign reg_idx  = word_idx[IDX_W-1:0];

   always_comb begin
      err              = '0;
      err.unaligned    = |(paddr & ADDR_W'(LANES - 1));
      err.out_of_range = {1'b0, word_idx} >= (ADDR_W+1)'(NUM_REGS);
      err.ro_write     = pwrite & ~err.out_of_range & RO_MASK[reg_idx];
   end

   assign error    = |err;
   assign complete = (state == ACCESS) && pselx && penable && (cnt == CNT_W'(WAIT_CYCLES));
   assign commit   = complete & pwrite & ~error;

   assign rd_word      = RO_MASK[reg_idx] ? ro_in[reg_idx*DATA_W +: DATA_W]
                                          : reg_out[reg_idx*DATA_W +: DATA_W];
   assign pready       = complete;
   assign pslave_error = complete & error;
   assign prdata       = (complete && !pwrite && !error) ? rd_word : '0;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      // SETUP is recognised in the same cycle the master presents it, so the
      // register already reads ACCESS during the first penable cycle.
      phase = state;
      if (state == IDLE && pselx && !penable) phase = SETUP;
      state_nxt = state;
      cnt_nxt   = cnt;
      case (phase)
         IDLE: state_nxt = IDLE;
         SETUP: begin
            state_nxt = ACCESS;
            cnt_nxt   = '0;
         end
         ACCESS: begin
            if (!pselx || complete) state_nxt = IDLE;
            else if (penable)       cnt_nxt   = cnt + CNT_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   apb_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .pclk     (pclk),
      .presetn  (presetn),
      .wr_vld   (commit),
      .wr_idx   (reg_idx),
      .wr_dat   (pwdata),
      .wr_strb  (pstrb),
      .reg_out  (reg_out),
      .wr_pulse (wr_pulse)
   );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (0/3/2 wait states, RO reg 3 on the first)
// checked every cycle against an APB-level model plus directed literal expectations.
module tb_apb_regfile_slave;

   localparam int NDUT = 3;

   logic        pclk    = 1'b0;
   logic        presetn = 1'b0;
   logic [31:0] paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic [3:0]  pstrb   = '0;
   logic        pwrite  = 1'b0;
   logic        penable = 1'b0;
   logic [NDUT-1:0]        psel = '0;
   logic [NDUT-1:0]        pready, perr;
   logic [NDUT-1:0][31:0]  prdata;
   logic [NDUT-1:0][511:0] reg_out;
   logic [NDUT-1:0][15:0]  wr_pulse;
   logic [511:0]           ro_in;

   int vectors     = 0;
   int miscompares = 0;

   always #5 pclk = ~pclk;

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
   endfunction

   function automatic logic [15:0] ro_of(input int k);
      return (k == 0) ? 16'h0008 : 16'h0000;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      apb_regfile_slave #(
         .ADDR_W(32), .DATA_W(32), .NUM_REGS(16),
         .WAIT_CYCLES(wait_of(g)), .RO_MASK(ro_of(g))
      ) dut (
         .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata),
         .pstrb(pstrb), .pwrite(pwrite), .pselx(psel[g]), .penable(penable),
         .prdata(prdata[g]), .pready(pready[g]), .pslave_error(perr[g]),
         .reg_out(reg_out[g]), .ro_in(ro_in), .wr_pulse(wr_pulse[g])
      );
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: register images, per-instance APB phase tracking, expected pulses.
   logic [31:0] mem [NDUT][16];
   int          acc [NDUT];
   bit          in_xfer [NDUT];
   logic [15:0] exp_pulse [NDUT];

   task automatic model_step(input int k);
      logic [31:0]  idx, rd;
      logic [15:0]  rom;
      logic [511:0] flat;
      logic         act, rdy, ro, er, commit;
      if (!presetn) begin
         for (int i = 0; i < 16; i++) mem[k][i] = '0;
         acc[k] = 0; in_xfer[k] = 0; exp_pulse[k] = '0;
      end
      idx = paddr >> 2;
      rom = ro_of(k);
      ro  = (idx < 16) && rom[idx[3:0]];
      er  = (paddr[1:0] != 2'b00) || (idx >= 16) || (pwrite && ro);
      act = presetn && psel[k] && penable && in_xfer[k];
      rdy = act && (acc[k] == wait_of(k));
      rd  = '0;
      if (rdy && !pwrite && !er) rd = ro ? ro_in[idx[3:0]*32 +: 32] : mem[k][idx[3:0]];
      for (int i = 0; i < 16; i++) flat[i*32 +: 32] = mem[k][i];
      check($sformatf("d%0d_pready", k), pready[k], rdy);
      check($sformatf("d%0d_perr", k), perr[k], rdy && er);
      check($sformatf("d%0d_prdata", k), prdata[k], rd);
      check($sformatf("d%0d_wr_pulse", k), wr_pulse[k], exp_pulse[k]);
      check($sformatf("d%0d_reg_out", k), reg_out[k], flat);
      if (presetn) begin
         commit       = rdy && pwrite && !er;
         exp_pulse[k] = commit ? (16'd1 << idx[3:0]) : 16'd0;
         if (commit)
            for (int j = 0; j < 4; j++)
               if (pstrb[j]) mem[k][idx[3:0]][8*j +: 8] = pwdata[8*j +: 8];
         if (!psel[k]) in_xfer[k] = 0;
         else if (!penable) begin in_xfer[k] = 1; acc[k] = 0; end
         else if (in_xfer[k]) begin
            if (rdy) in_xfer[k] = 0;
            else acc[k]++;
         end
      end
   endtask

   always @(negedge pclk) begin
      for (int k = 0; k < NDUT; k++) model_step(k);
   end

   task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic [3:0] strb,
                       output logic [31:0] rdat, output logic err, output int cycles);
      bit done = 0;
      @(posedge pclk); #1;
      psel = '0; psel[k] = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = wdat; pstrb = strb;
      cycles = 1; rdat = '0; err = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1; cycles = 2;
      while (!done) begin
         @(negedge pclk);
         if (pready[k]) begin
            rdat = prdata[k]; err = perr[k]; done = 1;
         end else if (cycles > 40) begin
            vectors++; miscompares++;
            $display("FAIL d%0d_timeout: no pready after %0d cycles, required within %0d", k, cycles, 2 + wait_of(k));
            done = 1;
         end else begin
            @(posedge pclk); #1;
            cycles++;
         end
      end
   endtask

   task automatic bus_idle();
      @(posedge pclk); #1;
      psel = '0; penable = 1'b0;
   endtask

   task automatic do_wr(input string tag, input int k, input logic [31:0] addr, input logic [31:0] d,
                        input logic [3:0] strb, input logic exp_err, input int exp_cyc);
      logic [31:0] r; logic e; int c;
      xfer(k, 1'b1, addr, d, strb, r, e, c);
      check({tag, "_err"}, e, exp_err);
      check({tag, "_cycles"}, c, exp_cyc);
   endtask

   task automatic do_rd(input string tag, input int k, input logic [31:0] addr, input logic [31:0] exp_d,
                        input logic exp_err, input int exp_cyc);
      logic [31:0] r; logic e; int c;
      xfer(k, 1'b0, addr, '0, 4'h0, r, e, c);
      check({tag, "_data"}, r, exp_d);
      check({tag, "_err"}, e, exp_err);
      check({tag, "_cycles"}, c, exp_cyc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen;
      for (int i = 0; i < 16; i++) ro_in[i*32 +: 32] = 32'hA500_0000 + 32'(i);
      ro_in[3*32 +: 32] = 32'hC0DE_0003;

      // Reset state
      repeat (3) @(negedge pclk);
      check("rst_reg_out", reg_out[0], '0);
      check("rst_prdata", prdata[0], '0);
      @(posedge pclk); #1 presetn = 1'b1;

      // Full write and read-back, zero wait states
      do_wr("w08", 0, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 2);
      bus_idle();
      @(negedge pclk);
      check("w08_pulse", wr_pulse[0], 16'h0004);
      check("w08_reg", reg_out[0][95:64], 32'hDEADBEEF);
      do_rd("r08", 0, 32'h08, 32'hDEADBEEF, 1'b0, 2);

      // Partial strobes, then an empty strobe
      do_wr("w04a", 0, 32'h04, 32'h11223344, 4'hF, 1'b0, 2);
      do_wr("w04b", 0, 32'h04, 32'hAABBCCDD, 4'h5, 1'b0, 2);
      do_rd("r04", 0, 32'h04, 32'h11BB33DD, 1'b0, 2);
      do_wr("w04z", 0, 32'h04, 32'hFFFFFFFF, 4'h0, 1'b0, 2);
      bus_idle();
      @(negedge pclk);
      check("w04z_pulse", wr_pulse[0], 16'h0002);
      do_rd("r04z", 0, 32'h04, 32'h11BB33DD, 1'b0, 2);

      // Three wait states with a back-to-back read
      do_wr("w3_0c", 1, 32'h0C, 32'h0BADF00D, 4'hF, 1'b0, 5);
      do_rd("r3_0c", 1, 32'h0C, 32'h0BADF00D, 1'b0, 5);
      bus_idle();

      // Error cases and the last register
      do_rd("r40", 0, 32'h40, 32'h0, 1'b1, 2);
      do_wr("w05", 0, 32'h05, 32'h12345678, 4'hF, 1'b1, 2);
      bus_idle();
      @(negedge pclk);
      check("w05_pulse", wr_pulse[0], 16'h0000);
      check("w05_reg1", reg_out[0][63:32], 32'h11BB33DD);
      do_wr("wro3", 0, 32'h0C, 32'h12345678, 4'hF, 1'b1, 2);
      do_rd("rro3", 0, 32'h0C, 32'hC0DE0003, 1'b0, 2);
      do_wr("w3c", 0, 32'h3C, 32'hCAFEF00D, 4'hF, 1'b0, 2);
      do_rd("r3c", 0, 32'h3C, 32'hCAFEF00D, 1'b0, 2);
      do_rd("r14", 0, 32'h14, 32'h0, 1'b0, 2);
      bus_idle();

      // Reset during the access wait of a write (two wait states)
      @(posedge pclk); #1;
      psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h10; pwdata = 32'h55AA55AA; pstrb = 4'hF;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk);
      check("rstmid_wait", pready[2], 1'b0);
      @(posedge pclk); #1 presetn = 1'b0;
      #1;
      check("rstmid_pready", pready[2], 1'b0);
      check("rstmid_reg", reg_out[2], '0);
      @(posedge pclk); #1 psel = '0; penable = 1'b0;
      @(posedge pclk); #1 presetn = 1'b1;
      do_rd("r10_post", 2, 32'h10, 32'h0, 1'b0, 4);
      do_wr("w10", 2, 32'h10, 32'h55AA55AA, 4'hF, 1'b0, 4);
      do_rd("r10", 2, 32'h10, 32'h55AA55AA, 1'b0, 4);
      bus_idle();

      // Select dropped during the access wait
      seen = 0;
      @(posedge pclk); #1;
      psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h18; pwdata = 32'h00000099; pstrb = 4'hF;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk); seen += int'(pready[1]);
      @(posedge pclk); #1 psel = '0; penable = 1'b0;
      repeat (3) begin
         @(negedge pclk);
         seen += int'(pready[1]);
         check("abort_pulse", wr_pulse[1], 16'h0000);
      end
      check("abort_pready_count", seen, 0);
      do_rd("r18", 1, 32'h18, 32'h0, 1'b0, 5);
      bus_idle();

      repeat (2) @(negedge pclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
